// File: rtl/pll_seq_pkg.sv
// Shared state encoding and reset-domain indices for the core PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } pll_seq_state_t;

  localparam int NUM_DOMAINS = 3;
  localparam int DOM_SYS     = 0;  // 110.592 MHz
  localparam int DOM_CPU     = 1;  // 36.864 MHz
  localparam int DOM_VIDEO   = 2;  // 6.144 MHz

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, cleared to 0 by an asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from the same edge; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a debounced lock, then releases the sys/cpu/video
// domain resets in a staggered order; re-runs the sequence on lock loss or timeout.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 74250,
  parameter int STAGE_GAP    = 64
) (
  input  logic                   clk_74a,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   force_reset,
  input  logic                   clear_status,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   ready,
  output logic [2:0]             retry_count,
  output logic                   lock_lost
);

  localparam int MAX_A     = (RST_HOLD > LOCK_STABLE) ? RST_HOLD : LOCK_STABLE;
  localparam int MAX_B     = (LOCK_TIMEOUT > STAGE_GAP) ? LOCK_TIMEOUT : STAGE_GAP;
  localparam int MAX_PARAM = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(MAX_PARAM) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // The extra counter bit lets RELEASE count both stage gaps without a second counter.
  localparam cnt_t HOLD_LAST    = cnt_t'(RST_HOLD - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STABLE_DONE  = cnt_t'(LOCK_STABLE);
  localparam cnt_t GAP1_LAST    = cnt_t'(STAGE_GAP - 1);
  localparam cnt_t GAP2_LAST    = cnt_t'(2 * STAGE_GAP - 1);
  localparam logic [2:0] RETRY_MAX = 3'd7;

  pll_seq_state_t         state_q, state_d;
  cnt_t                   cnt_q, cnt_d;
  logic                   lock_s;
  logic                   timeout;
  logic                   lock_drop;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic [2:0]             retry_d;
  logic                   lock_lost_d;

  sync_2ff u_lock_sync (
    .clk   (clk_74a),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    timeout   = 1'b0;
    lock_drop = 1'b0;

    case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = HOLD;
          timeout = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)                   state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_DONE) state_d = RELEASE;
      end
      RELEASE: begin
        if (!lock_s) begin
          state_d   = HOLD;
          lock_drop = 1'b1;
        end else if (cnt_q == GAP2_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = HOLD;
          lock_drop = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase

    // A forced restart pre-empts the timeout retry but still lets a coincident
    // lock drop be recorded in lock_lost.
    if (force_reset) begin
      state_d = HOLD;
      timeout = 1'b0;
    end

    if (force_reset || (state_d != state_q)) cnt_d = '0;
    else if (state_q == RUN)                 cnt_d = cnt_q;
    else                                     cnt_d = cnt_q + cnt_t'(1);

    dom_d = '0;
    case (state_d)
      RELEASE: begin
        if (state_q != RELEASE) begin
          dom_d[DOM_SYS] = 1'b1;
        end else begin
          dom_d = domain_reset_n;
          if (cnt_q == GAP1_LAST) dom_d[DOM_CPU] = 1'b1;
        end
      end
      RUN: begin
        dom_d            = domain_reset_n;
        dom_d[DOM_VIDEO] = 1'b1;
      end
      default: dom_d = '0;
    endcase

    // Set events take priority over a same-cycle clear.
    retry_d = retry_count;
    if (timeout)           retry_d = (retry_count == RETRY_MAX) ? RETRY_MAX : retry_count + 3'd1;
    else if (clear_status) retry_d = '0;

    lock_lost_d = lock_lost;
    if (lock_drop)         lock_lost_d = 1'b1;
    else if (clear_status) lock_lost_d = 1'b0;
  end

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= HOLD;
      cnt_q          <= '0;
      pll_rst        <= 1'b1;
      domain_reset_n <= '0;
      ready          <= 1'b0;
      retry_count    <= '0;
      lock_lost      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_rst        <= (state_d == HOLD);
      domain_reset_n <= dom_d;
      ready          <= (state_d == RUN);
      retry_count    <= retry_d;
      lock_lost      <= lock_lost_d;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed self-checking bench for pll_reset_sequencer with shortened timing parameters.
module tb_pll_reset_sequencer;

  logic       clk_74a = 1'b0;
  logic       reset_n = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_reset = 1'b0;
  logic       clear_status = 1'b0;
  logic       pll_rst;
  logic [2:0] domain_reset_n;
  logic       ready;
  logic [2:0] retry_count;
  logic       lock_lost;

  int checks   = 0;
  int failures = 0;

  always #5 clk_74a = ~clk_74a;

  pll_reset_sequencer #(
    .RST_HOLD     (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (32),
    .STAGE_GAP    (4)
  ) dut (
    .clk_74a        (clk_74a),
    .reset_n        (reset_n),
    .pll_locked     (pll_locked),
    .force_reset    (force_reset),
    .clear_status   (clear_status),
    .pll_rst        (pll_rst),
    .domain_reset_n (domain_reset_n),
    .ready          (ready),
    .retry_count    (retry_count),
    .lock_lost      (lock_lost)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge, then park on the falling edge for sampling/driving.
  task automatic cyc();
    @(posedge clk_74a);
    @(negedge clk_74a);
  endtask

  task automatic cyc_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic hold_reset();
    reset_n      = 1'b0;
    pll_locked   = 1'b0;
    force_reset  = 1'b0;
    clear_status = 1'b0;
    cyc_n(2);
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
  endtask

  task automatic wait_dom(input logic [2:0] val, input int budget, output int n);
    n = 0;
    while (domain_reset_n !== val && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_pll_rst(input logic val, input int budget, output int n);
    n = 0;
    while (pll_rst !== val && n < budget) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    hold_reset();
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    checks++; if (domain_reset_n !== 3'b000) begin failures++; $display("FAIL reset_dom: got %b want 000", domain_reset_n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (retry_count !== 3'd0) begin failures++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
  endtask

  task automatic test_clean_bringup();
    int n;
    release_reset();
    cyc_n(3);
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL clean_pll_rst_held: got %b want 1", pll_rst); end
    cyc();
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL clean_pll_rst_fall: got %b want 0", pll_rst); end
    cyc_n(5);
    pll_locked = 1'b1;  // first sampled high on edge 10
    wait_dom(3'b001, 200, n);
    checks++; if (n !== 12) begin failures++; $display("FAIL clean_lat_dom0: got %0d cycles want 12", n); end
    wait_dom(3'b011, 200, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL clean_gap_dom1: got %0d cycles want 4", n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL clean_ready_early: got %b want 0", ready); end
    wait_dom(3'b111, 200, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL clean_gap_dom2: got %0d cycles want 4", n); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL clean_ready: got %b want 1", ready); end
    checks++; if (retry_count !== 3'd0) begin failures++; $display("FAIL clean_retry: got %0d want 0", retry_count); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL clean_lock_lost: got %b want 0", lock_lost); end
  endtask

  task automatic test_retries();
    int n;
    hold_reset();
    release_reset();
    wait_pll_rst(1'b0, 100, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL retry_first_hold: got %0d cycles want 4", n); end
    for (int i = 0; i < 3; i++) begin
      wait_pll_rst(1'b1, 100, n);
      checks++; if (n !== 32) begin failures++; $display("FAIL retry_timeout_%0d: got %0d cycles want 32", i, n); end
      checks++; if (retry_count !== 3'(i + 1)) begin failures++; $display("FAIL retry_count_%0d: got %0d want %0d", i, retry_count, i + 1); end
      wait_pll_rst(1'b0, 100, n);
      checks++; if (n !== 4) begin failures++; $display("FAIL retry_hold_%0d: got %0d cycles want 4", i, n); end
    end
    pll_locked = 1'b1;
    wait_dom(3'b001, 200, n);
    checks++; if (n !== 12) begin failures++; $display("FAIL retry_lat_dom0: got %0d cycles want 12", n); end
    wait_dom(3'b111, 200, n);
    checks++; if (n !== 8) begin failures++; $display("FAIL retry_lat_run: got %0d cycles want 8", n); end
    checks++; if (retry_count !== 3'd3) begin failures++; $display("FAIL retry_final: got %0d want 3", retry_count); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL retry_ready: got %b want 1", ready); end
  endtask

  task automatic test_glitch_and_drop();
    int n;
    hold_reset();
    release_reset();
    wait_pll_rst(1'b0, 100, n);
    pll_locked = 1'b1;  // STABLE entered on the 3rd edge from here
    cyc_n(6);
    pll_locked = 1'b0;  // one low sample mid-STABLE
    cyc();
    pll_locked = 1'b1;
    wait_dom(3'b001, 200, n);
    checks++; if (n !== 12) begin failures++; $display("FAIL glitch_lat_dom0: got %0d cycles want 12", n); end
    checks++; if (retry_count !== 3'd0) begin failures++; $display("FAIL glitch_retry: got %0d want 0", retry_count); end
    wait_dom(3'b111, 200, n);
    checks++; if (n !== 8) begin failures++; $display("FAIL glitch_lat_run: got %0d cycles want 8", n); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL drop_ready_before: got %b want 1", ready); end
    pll_locked = 1'b0;
    cyc_n(2);
    checks++; if (domain_reset_n !== 3'b111) begin failures++; $display("FAIL drop_dom_early: got %b want 111", domain_reset_n); end
    cyc();
    checks++; if (domain_reset_n !== 3'b000) begin failures++; $display("FAIL drop_dom: got %b want 000", domain_reset_n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL drop_ready: got %b want 0", ready); end
    checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL drop_lock_lost: got %b want 1", lock_lost); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL drop_pll_rst: got %b want 1", pll_rst); end
    checks++; if (retry_count !== 3'd0) begin failures++; $display("FAIL drop_retry: got %0d want 0", retry_count); end
    clear_status = 1'b1;
    cyc();
    clear_status = 1'b0;
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL drop_clear: got %b want 0", lock_lost); end
  endtask

  task automatic test_saturation();
    logic [2:0] exp_cnt;
    hold_reset();
    release_reset();
    cyc_n(35);  // timeouts land on edges 36, 72, 108, ...
    for (int k = 1; k <= 9; k++) begin
      exp_cnt = (k - 1 > 7) ? 3'd7 : 3'(k - 1);
      checks++; if (retry_count !== exp_cnt) begin failures++; $display("FAIL sat_before_%0d: got %0d want %0d", k, retry_count, exp_cnt); end
      if (k == 9) clear_status = 1'b1;
      cyc();
      clear_status = 1'b0;
      exp_cnt = (k > 7) ? 3'd7 : 3'(k);
      checks++; if (retry_count !== exp_cnt) begin failures++; $display("FAIL sat_after_%0d: got %0d want %0d", k, retry_count, exp_cnt); end
      if (k < 9) cyc_n(35);
    end
    cyc();
    clear_status = 1'b1;
    cyc();
    clear_status = 1'b0;
    checks++; if (retry_count !== 3'd0) begin failures++; $display("FAIL sat_clear: got %0d want 0", retry_count); end
  endtask

  task automatic test_force();
    int n;
    hold_reset();
    release_reset();
    pll_locked = 1'b1;
    wait_dom(3'b001, 200, n);
    checks++; if (n !== 14) begin failures++; $display("FAIL force_lat_dom0: got %0d cycles want 14", n); end
    cyc();
    force_reset = 1'b1;
    cyc();
    checks++; if (domain_reset_n !== 3'b000) begin failures++; $display("FAIL force_dom: got %b want 000", domain_reset_n); end
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL force_pll_rst: got %b want 1", pll_rst); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL force_lock_lost: got %b want 0", lock_lost); end
    cyc_n(2);
    force_reset = 1'b0;
    cyc_n(3);
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL force_hold_held: got %b want 1", pll_rst); end
    cyc();
    checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL force_hold_fall: got %b want 0", pll_rst); end
    wait_dom(3'b001, 200, n);
    checks++; if (n !== 10) begin failures++; $display("FAIL force_relock_dom0: got %0d cycles want 10", n); end
    wait_dom(3'b111, 200, n);
    checks++; if (n !== 8) begin failures++; $display("FAIL force_relock_run: got %0d cycles want 8", n); end

    // force_reset coinciding with the synchronized lock drop in RUN
    pll_locked = 1'b0;
    cyc_n(2);
    force_reset = 1'b1;
    cyc();
    force_reset = 1'b0;
    pll_locked  = 1'b1;
    checks++; if (lock_lost !== 1'b1) begin failures++; $display("FAIL force_drop_lock_lost: got %b want 1", lock_lost); end
    checks++; if (domain_reset_n !== 3'b000) begin failures++; $display("FAIL force_drop_dom: got %b want 000", domain_reset_n); end
    checks++; if (retry_count !== 3'd0) begin failures++; $display("FAIL force_drop_retry: got %0d want 0", retry_count); end
    wait_dom(3'b111, 200, n);
    checks++; if (n !== 22) begin failures++; $display("FAIL force_drop_rerun: got %0d cycles want 22", n); end

    // asynchronous reset in RUN, checked before any further clock edge
    reset_n = 1'b0;
    #1;
    checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL async_pll_rst: got %b want 1", pll_rst); end
    checks++; if (domain_reset_n !== 3'b000) begin failures++; $display("FAIL async_dom: got %b want 000", domain_reset_n); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL async_ready: got %b want 0", ready); end
    checks++; if (lock_lost !== 1'b0) begin failures++; $display("FAIL async_lock_lost: got %b want 0", lock_lost); end
    checks++; if (retry_count !== 3'd0) begin failures++; $display("FAIL async_retry: got %0d want 0", retry_count); end
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_retries();
    test_glitch_and_drop();
    test_saturation();
    test_force();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
